// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND (7-segment) scan controller.
package fnd_pkg;

  localparam int unsigned FND_MAX_DIGITS = 8;
  localparam int unsigned FND_SEL_W      = 3;
  localparam logic [FND_MAX_DIGITS-1:0] FND_COM_OFF = 8'hFF;

  typedef logic [3:0] fnd_nibble_t;

  // Counter width for a 0..n-1 counter; a 1-bit register is kept even for n == 1.
  function automatic int unsigned fnd_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// Terminal-count prescaler: adv is high for one cycle out of every SCAN_DIV.
module fnd_prescaler
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic adv
);

  localparam int unsigned CntW = fnd_cnt_width(SCAN_DIV);
  localparam logic [CntW-1:0] LastCnt = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] pcnt_q, pcnt_d;

  assign adv = (pcnt_q == LastCnt);

  always_comb begin
    pcnt_d = adv ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining FND_LZ_BLANK_EN.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  output logic [FND_SEL_W-1:0]      sel,
  output logic [3:0]                din,
  output logic [FND_MAX_DIGITS-1:0] com,
  output logic                      pending,
  output logic                      frame_tick
);

  localparam logic [FND_SEL_W-1:0] LastSel = FND_SEL_W'(NUM_DIGITS - 1);

  logic                             adv;
  logic                             wrap;
  logic [FND_SEL_W-1:0]             sel_q, sel_d;
  fnd_nibble_t [NUM_DIGITS-1:0]     active_q, active_d;
  fnd_nibble_t [NUM_DIGITS-1:0]     shadow_q, shadow_d;
  logic                             pending_q, pending_d;
  logic                             frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]            blank;

  fnd_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .adv (adv)
  );

  // The wrap from the last digit back to digit 0 is the only commit point.
  assign wrap = adv && (sel_q == LastSel);

  always_comb begin
    sel_d        = sel_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;

    if (adv) begin
      sel_d = wrap ? '0 : sel_q + 1'b1;
    end

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    // A load coinciding with the wrap bypasses the shadow so the newest value wins.
    if (wrap) begin
      if (load) begin
        active_d = value;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef FND_LZ_BLANK_EN
  // Digit i (> 0) is blank when it and every more-significant digit are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_q[i] == 4'h0);
      blank[i]   = (i != 0) && zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    din = 4'h0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (sel_q == FND_SEL_W'(i)) begin
        din = active_q[i];
      end
    end
  end

  always_comb begin
    com = FND_COM_OFF;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((sel_q == FND_SEL_W'(i)) && !blank[i]) begin
        com[i] = 1'b0;
      end
    end
  end

  assign sel        = sel_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule
